// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the Lapido multicycle sequencer: state codes,
// instruction type codes, ALU opcode constants and small helpers.
package lapido_pkg;

  // State codes; also driven out on the phase port for debug.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_ALU = 4'd3,
    ST_WB_ALU   = 4'd4,
    ST_ADDR     = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_MEM_WR   = 4'd8
  } state_t;

  // Instruction type field instruction[31:29]
  localparam logic [2:0] TYPE_ALU = 3'b100;
  localparam logic [2:0] TYPE_MEM = 3'b001;

  // ALU function used for address generation
  localparam logic [4:0] ALUOP_ADD = 5'b00000;

  // Width of the memory wait counter
  localparam int unsigned WAIT_W = 8;

  // States that hold the memory port and wait for memReady
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle of the sequencer's datapath/memory control signals.
// master = sequencer side, slave = datapath/memory side.
import lapido_pkg::*;

interface multicycle_sequencer_if;
  logic [31:0]               instruction;
  logic                      memReady;
  logic                      pcWrite;
  logic                      irWrite;
  logic                      iOrD;
  logic                      memRead;
  logic                      memWrite;
  logic                      memToReg;
  logic                      ALUSrc;
  logic [4:0]                ALUOp;
  logic                      regWrite;
  logic                      illegal;
  logic                      busError;
  logic [$bits(state_t)-1:0] phase;

  modport master (
    input  instruction, memReady,
    output pcWrite, irWrite, iOrD, memRead, memWrite, memToReg,
           ALUSrc, ALUOp, regWrite, illegal, busError, phase
  );

  modport slave (
    output instruction, memReady,
    input  pcWrite, irWrite, iOrD, memRead, memWrite, memToReg,
           ALUSrc, ALUOp, regWrite, illegal, busError, phase
  );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for memReady and flags
// when the count has reached the configured timeout.
module mem_wait_timer
  import lapido_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [WAIT_W-1:0] LP_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] LP_MAX   = '1;

  logic [WAIT_W-1:0] r_count;
  logic [WAIT_W-1:0] w_count_next;

  // Next count: clear has priority, otherwise saturating increment
  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_count_en && (r_count != LP_MAX)) begin
      w_count_next = r_count + WAIT_W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_expired = (r_count == LP_LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the Lapido core. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives datapath strobes
// straight from the registered state, instruction and memReady.
module multicycle_sequencer
  import lapido_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;

  logic       w_expired;
  logic       w_timer_clear;
  logic       w_timer_en;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_i_or_d;
  logic       w_mem_read_n;
  logic       w_mem_write_n;
  logic       w_mem_to_reg;
  logic       w_alu_src;
  logic [4:0] w_alu_op;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_bus_error;

  logic [2:0] w_type;
  logic [4:0] w_func;
  logic       w_is_store;
  logic       w_unused;

  assign w_type     = bus.instruction[31:29];
  assign w_func     = bus.instruction[28:24];
  assign w_is_store = bus.instruction[24];
  assign w_unused   = ^bus.instruction[23:0];

  // Timer restarts whenever the current state instance ends (including a
  // timed-out fetch that loops back into FETCH), so every wait starts at 0.
  assign w_timer_clear = (w_state_next != r_state) || w_bus_error;
  assign w_timer_en    = is_wait_state(r_state) && !bus.memReady;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk      (clock),
    .i_srst     (reset),
    .i_clear    (w_timer_clear),
    .i_count_en (w_timer_en),
    .o_expired  (w_expired)
  );

  // State register; reset always lands in IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode; completion beats timeout in wait states
  always_comb begin
    w_state_next  = r_state;
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_i_or_d      = 1'b0;
    w_mem_read_n  = 1'b1;
    w_mem_write_n = 1'b1;
    w_mem_to_reg  = 1'b0;
    w_alu_src     = 1'b0;
    w_alu_op      = ALUOP_ADD;
    w_reg_write   = 1'b0;
    w_illegal     = 1'b0;
    w_bus_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_mem_read_n = 1'b0;
        if (bus.memReady) begin
          w_pc_write   = 1'b1;
          w_ir_write   = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (w_type == TYPE_ALU) begin
          w_state_next = ST_EXEC_ALU;
        end else if (w_type == TYPE_MEM) begin
          w_state_next = ST_ADDR;
        end else begin
          w_illegal    = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_EXEC_ALU: begin
        w_alu_op     = w_func;
        w_state_next = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        w_alu_op     = w_func;
        w_reg_write  = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_ADDR: begin
        w_alu_src    = 1'b1;
        w_state_next = w_is_store ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_mem_read_n = 1'b0;
        w_i_or_d     = 1'b1;
        w_alu_src    = 1'b1;
        if (bus.memReady) begin
          w_state_next = ST_WB_MEM;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_WB_MEM: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        w_mem_write_n = 1'b0;
        w_i_or_d      = 1'b1;
        w_alu_src     = 1'b1;
        if (bus.memReady) begin
          w_state_next = ST_FETCH;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.pcWrite  = w_pc_write;
  assign bus.irWrite  = w_ir_write;
  assign bus.iOrD     = w_i_or_d;
  assign bus.memRead  = w_mem_read_n;
  assign bus.memWrite = w_mem_write_n;
  assign bus.memToReg = w_mem_to_reg;
  assign bus.ALUSrc   = w_alu_src;
  assign bus.ALUOp    = w_alu_op;
  assign bus.regWrite = w_reg_write;
  assign bus.illegal  = w_illegal;
  assign bus.busError = w_bus_error;
  assign bus.phase    = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_sequencer;
  import lapido_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] phase;
    logic       pcw, irw, iord, mrd, mwr, m2r, src;
    logic [4:0] op;
    logic       regw, ill, berr;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] cur_ins = 32'h0;

  function automatic exp_t ex(input logic [3:0] ph, input logic pcw, input logic irw,
                              input logic iord, input logic mrd, input logic mwr,
                              input logic m2r, input logic src, input logic [4:0] op,
                              input logic regw, input logic ill, input logic berr);
    exp_t e;
    e = {ph, pcw, irw, iord, mrd, mwr, m2r, src, op, regw, ill, berr};
    return e;
  endfunction

  // Idle-style vector: all outputs at their defaults
  function automatic exp_t dflt(input logic [3:0] ph);
    return ex(ph, 0, 0, 0, 1, 1, 0, 0, 5'b00000, 0, 0, 0);
  endfunction

  // Monitor: compare DUT outputs to the oldest expected vector
  always @(negedge clock) begin
    exp_t  e;
    exp_t  act;
    string n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {bus.phase, bus.pcWrite, bus.irWrite, bus.iOrD, bus.memRead, bus.memWrite,
             bus.memToReg, bus.ALUSrc, bus.ALUOp, bus.regWrite, bus.illegal, bus.busError};
      tests++;
      if (act !== e) begin
        failed++;
        $display("FAIL %s: got %h (phase %0d) required %h (phase %0d)",
                 n, act, act.phase, e, e.phase);
      end
    end
  end

  // One clock cycle of stimulus; optionally queues the expected outputs
  task automatic step(input string nm, input logic rst, input logic rdy,
                      input exp_t e, input bit chk);
    @(posedge clock);
    #1;
    reset           = rst;
    bus.memReady    = rdy;
    bus.instruction = cur_ins;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  // FETCH with 'waits' idle cycles; give_up ends in a timeout instead of ready
  task automatic do_fetch(input string nm, input int waits, input bit give_up);
    for (int i = 0; i < waits; i++)
      step(nm, 0, 0, ex(ST_FETCH, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0,
                        give_up && (i == waits - 1)), 1);
    if (!give_up)
      step(nm, 0, 1, ex(ST_FETCH, 1, 1, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0), 1);
  endtask

  task automatic run_alu(input string nm, input logic [31:0] ins, input logic [4:0] op,
                         input int fwaits);
    $display("[TB] %s instr=%h", nm, ins);
    cur_ins = ins;
    do_fetch(nm, fwaits, 0);
    step(nm, 0, 0, dflt(ST_DECODE), 1);
    step(nm, 0, 1, ex(ST_EXEC_ALU, 0, 0, 0, 1, 1, 0, 0, op, 0, 0, 0), 1);
    step(nm, 0, 1, ex(ST_WB_ALU, 0, 0, 0, 1, 1, 0, 0, op, 1, 0, 0), 1);
  endtask

  task automatic run_load(input string nm, input logic [31:0] ins, input int waits,
                          input bit give_up);
    $display("[TB] %s instr=%h waits=%0d", nm, ins, waits);
    cur_ins = ins;
    do_fetch(nm, 0, 0);
    step(nm, 0, 0, dflt(ST_DECODE), 1);
    step(nm, 0, 1, ex(ST_ADDR, 0, 0, 0, 1, 1, 0, 1, 5'b00000, 0, 0, 0), 1);
    for (int i = 0; i < waits; i++)
      step(nm, 0, 0, ex(ST_MEM_RD, 0, 0, 1, 0, 1, 0, 1, 5'b00000, 0, 0,
                        give_up && (i == waits - 1)), 1);
    if (!give_up) begin
      step(nm, 0, 1, ex(ST_MEM_RD, 0, 0, 1, 0, 1, 0, 1, 5'b00000, 0, 0, 0), 1);
      step(nm, 0, 1, ex(ST_WB_MEM, 0, 0, 0, 1, 1, 1, 0, 5'b00000, 1, 0, 0), 1);
    end
  endtask

  task automatic run_store(input string nm, input logic [31:0] ins, input int waits,
                           input bit give_up);
    $display("[TB] %s instr=%h waits=%0d", nm, ins, waits);
    cur_ins = ins;
    do_fetch(nm, 0, 0);
    step(nm, 0, 1, dflt(ST_DECODE), 1);
    step(nm, 0, 1, ex(ST_ADDR, 0, 0, 0, 1, 1, 0, 1, 5'b00000, 0, 0, 0), 1);
    for (int i = 0; i < waits; i++)
      step(nm, 0, 0, ex(ST_MEM_WR, 0, 0, 1, 1, 0, 0, 1, 5'b00000, 0, 0,
                        give_up && (i == waits - 1)), 1);
    if (!give_up)
      step(nm, 0, 1, ex(ST_MEM_WR, 0, 0, 1, 1, 0, 0, 1, 5'b00000, 0, 0, 0), 1);
  endtask

  initial begin
    bus.instruction = 32'h0;
    bus.memReady    = 1'b0;
    reset           = 1'b1;
    @(posedge clock);

    // Reset held 3 cycles, then released: IDLE for 4 cycles
    $display("[TB] reset sequence");
    for (int i = 0; i < 3; i++) step("reset_hold", 1, 1, dflt(ST_IDLE), 1);
    step("reset_release", 0, 1, dflt(ST_IDLE), 1);

    // ALU op 01010, zero-wait fetch (cycle 5 is FETCH with memRead=0)
    run_alu("alu", 32'h8A00_0000, 5'b01010, 0);
    // Load with memReady delayed 2 cycles in MEM_RD
    run_load("load_wait2", 32'h2000_0004, 2, 0);
    // Store, zero wait
    run_store("store", 32'h2100_0000, 0, 0);
    // Unknown type: illegal pulse in DECODE, then straight to FETCH
    $display("[TB] illegal instr=e0000000");
    cur_ins = 32'hE000_0000;
    do_fetch("illegal", 0, 0);
    step("illegal", 0, 1, ex(ST_DECODE, 0, 0, 0, 1, 1, 0, 0, 5'b00000, 0, 1, 0), 1);
    // ALU with a different function and two fetch wait cycles
    run_alu("alu_fwait", 32'h9F00_0000, 5'b11111, 2);
    // Load timeout: busError on 16th MEM_RD cycle, then FETCH, no regWrite
    run_load("load_timeout", 32'h2000_0004, 16, 1);
    // Ready on the 16th cycle: completion wins
    run_load("load_ready16", 32'h2000_0004, 15, 0);
    // Store timeout
    run_store("store_timeout", 32'h2100_0000, 16, 1);
    // Fetch timeout retries with no pcWrite, then a normal fetch
    $display("[TB] fetch_timeout");
    cur_ins = 32'h8100_0000;
    do_fetch("fetch_timeout", 16, 1);
    run_alu("alu_after_to", 32'h8100_0000, 5'b00001, 0);
    // Reset in the middle of a MEM_RD wait
    $display("[TB] reset_mid_wait");
    cur_ins = 32'h2000_0004;
    do_fetch("rst_mid", 0, 0);
    step("rst_mid", 0, 0, dflt(ST_DECODE), 1);
    step("rst_mid", 0, 0, ex(ST_ADDR, 0, 0, 0, 1, 1, 0, 1, 5'b00000, 0, 0, 0), 1);
    for (int i = 0; i < 3; i++)
      step("rst_mid", 0, 0, ex(ST_MEM_RD, 0, 0, 1, 0, 1, 0, 1, 5'b00000, 0, 0, 0), 1);
    step("rst_mid_assert", 1, 1, dflt(ST_IDLE), 0);
    step("rst_mid_idle", 0, 1, dflt(ST_IDLE), 1);
    run_alu("alu_recover", 32'h8A00_0000, 5'b01010, 0);
    step("final_fetch", 0, 0, ex(ST_FETCH, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0), 1);

    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
